// File: rtl/sap_sequencer.sv
// rtl/sap_sequencer.sv - SAP micro-sequencer: variable-length T-states, halt/resume, single-step
module sap_sequencer #(
    parameter int OPW         = 4,
    parameter int VAR_LEN     = 1,
    parameter int HOLD_CYCLES = 1,
    parameter int CNTW        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    input  logic            flag_z,
    input  logic            flag_c,
    input  logic            step_mode,
    input  logic            step,
    input  logic            run,
    output logic [15:0]     ctrl,
    output logic [3:0]      stage,
    output logic            halted,
    output logic            instr_done,
    output logic [CNTW-1:0] icount
);

    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_IDLE = 4'd6,
        ST_HALT = 4'd7,
        ST_WAIT = 4'd8
    } stage_e;

    localparam logic [3:0] OP_HLT = 4'd0;
    localparam logic [3:0] OP_NOP = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_LDA = 4'd4;
    localparam logic [3:0] OP_OUT = 4'd5;
    localparam logic [3:0] OP_STA = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_JC  = 4'd9;

    localparam int B_FLAGS_LOAD = 15;
    localparam int B_PC_INC     = 14;
    localparam int B_PC_EN      = 13;
    localparam int B_PC_LOAD    = 12;
    localparam int B_MAR_ADDR_N = 11;
    localparam int B_MAR_MEM_N  = 10;
    localparam int B_RAM_EN_N   = 9;
    localparam int B_RAM_LOAD_N = 8;
    localparam int B_IR_LOAD_N  = 7;
    localparam int B_IR_EN_N    = 6;
    localparam int B_REGA_LD_N  = 5;
    localparam int B_REGA_EN    = 4;
    localparam int B_ADDER_SUB  = 3;
    localparam int B_REGB_EN    = 2;
    localparam int B_REGB_LD_N  = 1;
    localparam int B_OUT_LD_N   = 0;

    localparam logic [15:0] IDLE_WORD = 16'h0FE3;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    stage_e          stage_q, stage_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            instr_done_q;
    logic [CNTW-1:0] icount_q;
    logic            run_s_q, run_p_q, step_s_q, step_p_q;
    logic [15:0]     ctrl_q, ctrl_d;
    logic [3:0]      op;
    stage_e          last_stg;
    logic            retire;
    logic            run_rise, step_rise, jump_take;

    // Opcodes with any bit set above the 4-bit field behave as NOP.
    generate
        if (OPW > 4) begin : g_wide_op
            assign op = (|opcode[OPW-1:4]) ? OP_NOP : opcode[3:0];
        end else begin : g_narrow_op
            assign op = opcode[3:0];
        end
    endgenerate

    assign run_rise  = run_s_q & ~run_p_q;
    assign step_rise = step_s_q & ~step_p_q;
    assign jump_take = (op == OP_JMP) || ((op == OP_JZ) && flag_z) || ((op == OP_JC) && flag_c);

    always_comb begin
        last_stg = ST_T5;
        if (VAR_LEN != 0) begin
            case (op)
                OP_LDA:                 last_stg = ST_T4;
                OP_ADD, OP_SUB, OP_STA: last_stg = ST_T5;
                default:                last_stg = ST_T3;
            endcase
        end
        // HLT always retires at T3, even with legacy timing.
        if (op == OP_HLT) begin
            last_stg = ST_T3;
        end
    end

    always_comb begin
        stage_d = stage_q;
        hold_d  = '0;
        retire  = 1'b0;
        case (stage_q)
            ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5: begin
                if (stage_q == last_stg) begin
                    retire = 1'b1;
                    if (op == OP_HLT) begin
                        stage_d = ST_HALT;
                    end else if (step_mode) begin
                        stage_d = ST_WAIT;
                    end else begin
                        stage_d = ST_T0;
                    end
                end else begin
                    stage_d = stage_e'(stage_q + 4'd1);
                end
            end
            ST_IDLE: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    stage_d = ST_T0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_HALT: begin
                if (run_rise) begin
                    stage_d = ST_T0;
                end
            end
            ST_WAIT: begin
                if (step_rise || !step_mode) begin
                    stage_d = ST_T0;
                end
            end
            default: stage_d = ST_IDLE;
        endcase
    end

    // Edge detectors reset to 1 so a level already high at reset is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q      <= ST_IDLE;
            hold_q       <= '0;
            instr_done_q <= 1'b0;
            icount_q     <= '0;
            run_s_q      <= 1'b1;
            run_p_q      <= 1'b1;
            step_s_q     <= 1'b1;
            step_p_q     <= 1'b1;
        end else begin
            stage_q      <= stage_d;
            hold_q       <= hold_d;
            instr_done_q <= retire;
            if (retire) begin
                icount_q <= icount_q + 1'b1;
            end
            run_s_q      <= run;
            run_p_q      <= run_s_q;
            step_s_q     <= step;
            step_p_q     <= step_s_q;
        end
    end

    always_comb begin
        ctrl_d = IDLE_WORD;
        case (stage_q)
            ST_T0: begin
                ctrl_d[B_PC_EN]      = 1'b1;
                ctrl_d[B_MAR_ADDR_N] = 1'b0;
            end
            ST_T1: ctrl_d[B_PC_INC] = 1'b1;
            ST_T2: begin
                ctrl_d[B_RAM_EN_N]  = 1'b0;
                ctrl_d[B_IR_LOAD_N] = 1'b0;
            end
            ST_T3: begin
                if ((op == OP_ADD) || (op == OP_SUB) || (op == OP_LDA) || (op == OP_STA)) begin
                    ctrl_d[B_IR_EN_N]    = 1'b0;
                    ctrl_d[B_MAR_ADDR_N] = 1'b0;
                end else if (op == OP_OUT) begin
                    ctrl_d[B_REGA_EN]  = 1'b1;
                    ctrl_d[B_OUT_LD_N] = 1'b0;
                end else if (jump_take) begin
                    ctrl_d[B_IR_EN_N] = 1'b0;
                    ctrl_d[B_PC_LOAD] = 1'b1;
                end
            end
            ST_T4: begin
                if ((op == OP_ADD) || (op == OP_SUB)) begin
                    ctrl_d[B_RAM_EN_N]  = 1'b0;
                    ctrl_d[B_REGB_LD_N] = 1'b0;
                end else if (op == OP_LDA) begin
                    ctrl_d[B_RAM_EN_N]  = 1'b0;
                    ctrl_d[B_REGA_LD_N] = 1'b0;
                end else if (op == OP_STA) begin
                    ctrl_d[B_REGA_EN]   = 1'b1;
                    ctrl_d[B_MAR_MEM_N] = 1'b0;
                end
            end
            ST_T5: begin
                if ((op == OP_ADD) || (op == OP_SUB)) begin
                    ctrl_d[B_REGB_EN]    = 1'b1;
                    ctrl_d[B_REGA_LD_N]  = 1'b0;
                    ctrl_d[B_FLAGS_LOAD] = 1'b1;
                    ctrl_d[B_ADDER_SUB]  = (op == OP_SUB);
                end else if (op == OP_STA) begin
                    ctrl_d[B_RAM_LOAD_N] = 1'b0;
                end
            end
            default: ctrl_d = IDLE_WORD;
        endcase
    end

    // Falling-edge register keeps ctrl stable across the next rising edge.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            ctrl_q <= IDLE_WORD;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign ctrl       = ctrl_q;
    assign stage      = stage_q;
    assign halted     = (stage_q == ST_HALT);
    assign instr_done = instr_done_q;
    assign icount     = icount_q;

endmodule
